// File: rtl/cu_pkg.sv
// Shared types and instruction-field layout for the multi-cycle control unit.
// Field positions are functions so every module derives them from its own parameters.
package cu_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_DECODE     = 3'd1,
      S_EXECUTE    = 3'd2,
      S_MEM_ACCESS = 3'd3,
      S_WRITE_BACK = 3'd4
   } cu_state_e;

   typedef enum logic [1:0] {
      T_NOP   = 2'b00,
      T_STD   = 2'b01,
      T_LOAD  = 2'b10,
      T_STORE = 2'b11
   } instr_type_e;

   localparam logic [3:0] RESET_OPCODE = 4'hF;
   localparam int         OPCODE_W     = 4;
   localparam int         OPCODE_LSB   = 0;
   localparam int         OFFSET_LSB   = OPCODE_LSB + OPCODE_W;

   // Layout MSB->LSB: type[2], rd, rs1, rs2, offset[data_width], opcode[4]
   function automatic int rs2_lsb(input int data_width);
      return OFFSET_LSB + data_width;
   endfunction

   function automatic int rs1_lsb(input int reg_bits, input int data_width);
      return rs2_lsb(data_width) + reg_bits;
   endfunction

   function automatic int rd_lsb(input int reg_bits, input int data_width);
      return rs1_lsb(reg_bits, data_width) + reg_bits;
   endfunction

   function automatic int type_lsb(input int reg_bits, input int data_width);
      return rd_lsb(reg_bits, data_width) + reg_bits;
   endfunction

   function automatic int instr_width(input int reg_bits, input int data_width);
      return 2 + 3 * reg_bits + data_width + OPCODE_W;
   endfunction

endpackage

// File: rtl/cu_regfile.sv
// Register file for the control unit: two read ports sampled by the FSM in DECODE,
// one combinational debug read, one write port; resets each entry to its own index.
module cu_regfile
   import cu_pkg::*;
#(
   parameter int  DATA_WIDTH = 8,
   parameter int  NUM_REGS   = 4,
   localparam int REG_BITS   = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_BITS-1:0]   raddr_a_i,
   output logic [DATA_WIDTH-1:0] rdata_a_o,
   input  logic [REG_BITS-1:0]   raddr_b_i,
   output logic [DATA_WIDTH-1:0] rdata_b_o,
   input  logic [REG_BITS-1:0]   dbg_addr_i,
   output logic [DATA_WIDTH-1:0] dbg_data_o,
   input  logic                  we_i,
   input  logic [REG_BITS-1:0]   waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= DATA_WIDTH'(i);
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o  = regs_q[raddr_a_i];
   assign rdata_b_o  = regs_q[raddr_b_i];
   assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: one instruction per handshake, sequenced through
// DECODE / EXECUTE / MEM_ACCESS / WRITE_BACK with registered datapath controls.
//
// state        | meaning
// IDLE         | ready for an instruction; NOPs are consumed here
// DECODE       | read rs1 and rs2/rd, register operands and selects
// EXECUTE      | ALU works on registered operands; pick WB or MEM next
// MEM_ACCESS   | data memory access, held while mem_wait; store completes here
// WRITE_BACK   | result2 written to rd at end of cycle; done pulses
module cu_multicycle
   import cu_pkg::*;
#(
   parameter int  DATA_WIDTH  = 8,
   parameter int  NUM_REGS    = 4,
   localparam int REG_BITS    = $clog2(NUM_REGS),
   localparam int INSTR_WIDTH = instr_width(REG_BITS, DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic [DATA_WIDTH-1:0]  result2,
   input  logic                   mem_wait,
   output logic [DATA_WIDTH-1:0]  operand1,
   output logic [DATA_WIDTH-1:0]  operand2,
   output logic [DATA_WIDTH-1:0]  offset,
   output logic [3:0]             opcode,
   output logic                   sel1,
   output logic                   sel3,
   output logic                   w_r,
   output logic                   done,
   input  logic [REG_BITS-1:0]    dbg_addr,
   output logic [DATA_WIDTH-1:0]  dbg_data
);

   localparam int TYPE_LSB = type_lsb(REG_BITS, DATA_WIDTH);
   localparam int RD_LSB   = rd_lsb(REG_BITS, DATA_WIDTH);
   localparam int RS1_LSB  = rs1_lsb(REG_BITS, DATA_WIDTH);
   localparam int RS2_LSB  = rs2_lsb(DATA_WIDTH);

   cu_state_e              state_q;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic [DATA_WIDTH-1:0]  operand1_q, operand2_q, offset_q;
   logic [3:0]             opcode_q;
   logic                   sel1_q, sel3_q, w_r_q;

   logic [1:0]             in_type;
   instr_type_e            q_type;
   logic [REG_BITS-1:0]    q_rd, q_rs1, q_rs2;
   logic [DATA_WIDTH-1:0]  q_offset;
   logic [3:0]             q_opcode;
   logic [REG_BITS-1:0]    raddr_b;
   logic [DATA_WIDTH-1:0]  rdata_a, rdata_b;
   logic                   rf_we;

   assign in_type  = instr[TYPE_LSB +: 2];
   assign q_type   = instr_type_e'(instr_q[TYPE_LSB +: 2]);
   assign q_rd     = instr_q[RD_LSB +: REG_BITS];
   assign q_rs1    = instr_q[RS1_LSB +: REG_BITS];
   assign q_rs2    = instr_q[RS2_LSB +: REG_BITS];
   assign q_offset = instr_q[OFFSET_LSB +: DATA_WIDTH];
   assign q_opcode = instr_q[OPCODE_LSB +: OPCODE_W];

   // Load/store carry the store data / load target in rd, so port B reads rd for them
   assign raddr_b = (q_type == T_STD) ? q_rs2 : q_rd;
   assign rf_we   = (state_q == S_WRITE_BACK);

   cu_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst),
      .raddr_a_i  (q_rs1),
      .rdata_a_o  (rdata_a),
      .raddr_b_i  (raddr_b),
      .rdata_b_o  (rdata_b),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
      .we_i       (rf_we),
      .waddr_i    (q_rd),
      .wdata_i    (result2)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         instr_q    <= '0;
         operand1_q <= '0;
         operand2_q <= '0;
         offset_q   <= '0;
         opcode_q   <= RESET_OPCODE;
         sel1_q     <= 1'b0;
         sel3_q     <= 1'b0;
         w_r_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (instr_valid && (in_type != T_NOP)) begin
                  instr_q <= instr;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               operand1_q <= rdata_a;
               operand2_q <= rdata_b;
               offset_q   <= q_offset;
               opcode_q   <= q_opcode;
               sel1_q     <= (q_type == T_STD);
               sel3_q     <= (q_type != T_STD);
               state_q    <= S_EXECUTE;
            end
            S_EXECUTE: begin
               if (q_type == T_STD) begin
                  state_q <= S_WRITE_BACK;
               end else begin
                  state_q <= S_MEM_ACCESS;
                  w_r_q   <= (q_type == T_STORE);
               end
            end
            S_MEM_ACCESS: begin
               if (!mem_wait) begin
                  w_r_q   <= 1'b0;
                  state_q <= (q_type == T_LOAD) ? S_WRITE_BACK : S_IDLE;
               end
            end
            S_WRITE_BACK: begin
               state_q <= S_IDLE;
            end
            default: begin
               w_r_q   <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   // Store completes in MEM_ACCESS itself, so done must see the live mem_wait
   assign done = (state_q == S_WRITE_BACK) ||
                 ((state_q == S_MEM_ACCESS) && (q_type == T_STORE) && !mem_wait);

   assign operand1 = operand1_q;
   assign operand2 = operand2_q;
   assign offset   = offset_q;
   assign opcode   = opcode_q;
   assign sel1     = sel1_q;
   assign sel3     = sel3_q;
   assign w_r      = w_r_q;

endmodule

// File: tb/tb_cu_multicycle.sv
// Scoreboard bench for cu_multicycle: the driver pushes expected completions computed
// from a plain register-array model; a negedge monitor checks done, operands and w_r.
module tb_cu_multicycle;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int RB = 2;
   localparam int IW = 2 + 3 * RB + DW + 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] result2;
   logic          mem_wait;
   logic [DW-1:0] operand1, operand2, offset;
   logic [3:0]    opcode;
   logic          sel1, sel3, w_r, done;
   logic [RB-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   cu_multicycle #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .result2     (result2),
      .mem_wait    (mem_wait),
      .operand1    (operand1),
      .operand2    (operand2),
      .offset      (offset),
      .opcode      (opcode),
      .sel1        (sel1),
      .sel3        (sel3),
      .w_r         (w_r),
      .done        (done),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            hs;
      int            lat;
      bit            is_store;
      int            n;
      logic [DW-1:0] op1;
      logic [DW-1:0] op2;
      logic [DW-1:0] off;
      logic [3:0]    opc;
      bit            s1;
      bit            s3;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] model [NR];
   int            n_checks = 0;
   int            n_fail   = 0;
   bit            mon_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: runs mid-cycle, after all inputs for the cycle are settled
   always @(negedge clk) begin : monitor
      exp_t e;
      int   k;
      bit   exp_wr;
      if (mon_en) begin
         exp_wr = 1'b0;
         if (sb.size() > 0) begin
            k      = cyc - sb[0].hs + 1;
            exp_wr = sb[0].is_store && (k >= 3) && (k <= 3 + sb[0].n);
            if (k == 2) begin
               chk("operand1_cycle2", operand1, sb[0].op1);
               chk("operand2_cycle2", operand2, sb[0].op2);
            end
         end
         chk("w_r", w_r, exp_wr);
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", done, 1'b0);
            end else begin
               e = sb.pop_front();
               k = cyc - e.hs + 1;
               chk("done_cycle", k, e.lat);
               chk("operand1", operand1, e.op1);
               chk("operand2", operand2, e.op2);
               chk("offset", offset, e.off);
               chk("opcode", opcode, e.opc);
               chk("sel1", sel1, e.s1);
               chk("sel3", sel3, e.s3);
            end
         end else if (sb.size() > 0 && (cyc - sb[0].hs + 1) > sb[0].lat) begin
            chk("done_missing", done, 1'b1);
            void'(sb.pop_front());
         end
      end
   end

   task automatic wait_ready();
      int waited = 0;
      while (instr_ready !== 1'b1 && waited < 30) begin
         @(posedge clk); #1;
         waited++;
      end
      if (instr_ready !== 1'b1) chk("ready_timeout", instr_ready, 1'b1);
   endtask

   task automatic issue(input logic [1:0] t, input int rd, input int rs1, input int rs2,
                        input logic [DW-1:0] off, input logic [3:0] opc,
                        input logic [DW-1:0] r2, input int n, input bit junk);
      exp_t e;
      wait_ready();
      instr       = {t, RB'(rd), RB'(rs1), RB'(rs2), off, opc};
      instr_valid = 1'b1;
      result2     = r2;
      mem_wait    = 1'b0;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      if (t == 2'b00) return;
      e.hs       = cyc;
      e.is_store = (t == 2'b11);
      e.n        = n;
      e.op1      = model[rs1];
      e.op2      = (t == 2'b01) ? model[rs2] : model[rd];
      e.off      = off;
      e.opc      = opc;
      e.s1       = (t == 2'b01);
      e.s3       = (t != 2'b01);
      e.lat      = (t == 2'b01) ? 3 : (t == 2'b10) ? 4 + n : 3 + n;
      sb.push_back(e);
      if (t != 2'b11) model[rd] = r2;
      for (int k = 1; k <= e.lat; k++) begin
         mem_wait = (n > 0) && (k <= 2 + n);
         if (junk) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr       = IW'($urandom);
         end
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      mem_wait    = 1'b0;
   endtask

   task automatic dbg_sweep(input string tag);
      for (int i = 0; i < NR; i++) begin
         dbg_addr = RB'(i);
         #1;
         chk(tag, dbg_data, model[i]);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b0;
      instr       = '0;
      instr_valid = 1'b0;
      result2     = '0;
      mem_wait    = 1'b0;
      dbg_addr    = '0;
      for (int i = 0; i < NR; i++) model[i] = DW'(i);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_opcode", opcode, 4'hF);
      chk("rst_operand1", operand1, 0);
      chk("rst_operand2", operand2, 0);
      chk("rst_offset", offset, 0);
      chk("rst_sel1", sel1, 0);
      chk("rst_sel3", sel3, 0);
      chk("rst_w_r", w_r, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", instr_ready, 1);
      dbg_sweep("rst_dbg");
      @(posedge clk); #1;
      mon_en = 1'b1;

      issue(2'b01, 3, 1, 2, 8'h00, 4'h0, 8'd3, 0, 1'b0);
      issue(2'b10, 2, 1, 0, 8'd5, 4'h0, 8'hAA, 2, 1'b0);
      issue(2'b11, 3, 0, 0, 8'd4, 4'h0, 8'h55, 0, 1'b0);
      dbg_sweep("directed_dbg");
      issue(2'b00, 1, 1, 1, 8'h00, 4'h0, 8'h77, 0, 1'b0);
      issue(2'b01, 0, 2, 3, 8'h12, 4'h9, 8'hC3, 1, 1'b1);
      issue(2'b01, 1, 0, 0, 8'h34, 4'h2, 8'h5A, 0, 1'b0);
      dbg_sweep("busy_dbg");

      for (int j = 0; j < 60; j++) begin
         issue(2'($urandom_range(0, 3)), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
               $urandom_range(0, NR - 1), DW'($urandom), 4'($urandom), DW'($urandom),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      dbg_sweep("random_dbg");

      wait_ready();
      mon_en      = 1'b0;
      instr       = {2'b11, RB'(3), RB'(0), RB'(0), 8'd4, 4'h0};
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      mem_wait    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("stall_w_r", w_r, 1);
      rst = 1'b0;
      #1;
      chk("rst_mid_w_r", w_r, 0);
      chk("rst_mid_ready", instr_ready, 1);
      chk("rst_mid_done", done, 0);
      for (int i = 0; i < NR; i++) model[i] = DW'(i);
      dbg_sweep("rst_mid_dbg");
      @(negedge clk);
      rst      = 1'b1;
      mem_wait = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      issue(2'b01, 2, 3, 1, 8'h01, 4'h5, 8'h3C, 0, 1'b0);
      dbg_sweep("post_rst_dbg");
      repeat (2) @(posedge clk);
      chk("queue_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cu_multicycle.md
# cu_multicycle

Parametrised multi-cycle control unit for the teaching datapath: accepts one instruction per handshake, decodes it against an internal register file of NUM_REGS entries, and sequences the datapath through DECODE, EXECUTE, optional MEM_ACCESS and WRITE_BACK. It drives the ALU/data-memory controls (operand1, operand2, offset, opcode, sel1, sel3, w_r) and writes result2 back to the register file. Over the previous control unit it adds parametrised register count, a valid/ready instruction handshake, memory-stall support, a done pulse and a debug read port.

## Interface
- DATA_WIDTH, 8, datapath and register width
- NUM_REGS, 4, register-file depth; power of two, at least 2
- REG_BITS, derived log2(NUM_REGS), register index width (localparam)
- INSTR_WIDTH, derived 2+3*REG_BITS+DATA_WIDTH+4 (20 at defaults) (localparam)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- instr  in  INSTR_WIDTH  fields MSB→LSB: type[2], rd, rs1, rs2, offset[DATA_WIDTH], opcode[4]
- instr_valid  in  1  instr is presented
- instr_ready  out  1  unit idle, accepts instr this cycle
- result2  in  DATA_WIDTH  ALU result or memory read data for write-back
- mem_wait  in  1  data memory stall; sampled only in MEM_ACCESS
- operand1, operand2, offset  out  DATA_WIDTH  datapath operands
- opcode  out  4  ALU opcode
- sel1, sel3, w_r  out  1  ALU-result select, offset select, memory write enable
- done  out  1  one-cycle completion pulse
- dbg_addr  in  REG_BITS  debug read index
- dbg_data  out  DATA_WIDTH  regfile[dbg_addr], combinational

## Operation
- Types: 00 NOP, 01 std_op (rd←ALU(rs1,rs2)), 10 loadR (rd←mem[rs1+offset]), 11 storeR (mem[rs1+offset]←rd).
- Reset: state IDLE; operand1/operand2/offset 0, opcode 4'hF, sel1/sel3/w_r 0, done 0; regfile[i]=i mod 2^DATA_WIDTH; latched instruction 0.
- IDLE: instr_ready=1. instr_valid&&type≠00 → latch instr, go DECODE. instr_valid&&type=00 → consumed, stay IDLE, no done.
- DECODE: register operand1=regfile[rs1]; operand2=regfile[rs2] (std) or regfile[rd] (load/store); offset, opcode from instr; std: sel1=1,sel3=0; load/store: sel1=0,sel3=1 → EXECUTE.
- EXECUTE: std → WRITE_BACK; load/store → MEM_ACCESS; w_r←1 on entry to MEM_ACCESS for store only.
- MEM_ACCESS: mem_wait=1 → stay, outputs held. mem_wait=0: load → WRITE_BACK; store → IDLE, w_r←0, done=1 this cycle.
- WRITE_BACK: regfile[rd]←result2 at cycle end; done=1; → IDLE.
- Datapath outputs hold between instructions; w_r only high in store MEM_ACCESS.
- Single-issue: next DECODE sees prior write-back, no hazard logic. rd=0 writable.
- Illegal state encoding → IDLE next edge.

## Timing
- Cycle 0 = handshake edge. Operands valid from cycle 2 (EXECUTE) on.
- std: DECODE 1, EXECUTE 2, WRITE_BACK 3 (done); instr_ready again cycle 4.
- load: done in cycle 4+N, N = mem_wait cycles; store: done in cycle 3+N, w_r high cycles 3..3+N.
- done combinational from state (and mem_wait); instr_ready = (state==IDLE).
- instr_valid while busy ignored, not latched.
- rst low mid-operation: immediate return to reset values; w_r drops asynchronously; no regfile write.

## Structure
- Package cu_pkg: state enum (IDLE, DECODE, EXECUTE, MEM_ACCESS, WRITE_BACK), type codes, RESET_OPCODE=4'hF, field-offset localparams as functions of REG_BITS/DATA_WIDTH.
- Sub-module cu_regfile: NUM_REGS×DATA_WIDTH, two sync-timed reads used in DECODE, one combinational debug read, one write, async reset to index values.

## Test plan
- Reset, defaults: after rst release → opcode=4'hF, others 0, instr_ready=1, dbg reads 0,1,2,3.
- std_op rd=3,rs1=1,rs2=2,opcode=0, result2=8'd3 → cycle2 operand1=1,operand2=2,sel1=1; done cycle3; dbg_data[3]=3.
- loadR rd=2,rs1=1,offset=5, mem_wait high 2 cycles, result2=8'hAA → sel3=1, offset=5, done cycle 6, reg2=8'hAA.
- storeR rd=3,rs1=0,offset=4, mem_wait=0 → w_r=1 exactly cycle 3, done cycle 3, regfile unchanged.
- NOP and busy: NOP accepted, no done; instr_valid during std op → ignored, next valid instr executes normally.
- rst asserted during store MEM_ACCESS stall → w_r=0 immediately, regfile back to index values, instr_ready=1.
